led_strand_driver: RTL and testbench



---
 rtl/led_strand_driver_pkg.sv | 20 ++
 rtl/led_strand_driver_if.sv | 24 ++
 rtl/led_strand_driver_bit_encoder.sv | 59 +++++
 rtl/led_strand_driver.sv | 150 +++++++++++++++
 tb/tb_led_strand_driver.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/led_strand_driver_pkg.sv
// Shared types for the WS2812 strand driver: colour record, FSM states, helpers.
package led_strand_driver_pkg;

  localparam int CHAN_W       = 8;
  localparam int BITS_PER_LED = 3 * CHAN_W;

  typedef struct packed {
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] b;
  } led_color_t;

  typedef enum logic [1:0] {ST_LATCH, ST_FETCH, ST_SEND, ST_STALL} drv_state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_HIGH, PH_LOW} bit_phase_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_strand_driver_if.sv
// Colour request channel between the strand driver (master) and a pattern source (slave).
interface led_strand_driver_if
  import led_strand_driver_pkg::*;
#(
  parameter int COLOR_WIDTH       = CHAN_W,
  parameter int LED_COUNTER_WIDTH = 5
);
  logic [COLOR_WIDTH-1:0]       green_in;
  logic [COLOR_WIDTH-1:0]       red_in;
  logic [COLOR_WIDTH-1:0]       blue_in;
  logic                         color_ready;
  logic [LED_COUNTER_WIDTH-1:0] next_led_request;
  logic                         request_valid;

  modport master (
    output next_led_request, request_valid,
    input  green_in, red_in, blue_in, color_ready
  );

  modport slave (
    input  next_led_request, request_valid,
    output green_in, red_in, blue_in, color_ready
  );
endinterface

// File: rtl/led_strand_driver_bit_encoder.sv
// Emits one NRZ-timed bit per start pulse: high phase begins the cycle after start.
// done flags the final low cycle so a back-to-back start keeps the bit period exact.
module led_strand_driver_bit_encoder
  import led_strand_driver_pkg::*;
#(
  parameter int T0H_CYCLES = 35,
  parameter int T0L_CYCLES = 80,
  parameter int T1H_CYCLES = 70,
  parameter int T1L_CYCLES = 60
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic start,
  input  logic bit_in,
  output logic done,
  output logic strand_out
);

  localparam int CW = $clog2(max_of(max_of(T0H_CYCLES, T0L_CYCLES),
                                    max_of(T1H_CYCLES, T1L_CYCLES)) + 1);

  bit_phase_t    phase;
  logic [CW-1:0] cnt;
  logic          bit_q;

  assign done = (phase == PH_LOW) && (cnt == '0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase      <= PH_IDLE;
      cnt        <= '0;
      bit_q      <= 1'b0;
      strand_out <= 1'b0;
    end else if (start) begin
      phase      <= PH_HIGH;
      bit_q      <= bit_in;
      cnt        <= bit_in ? CW'(T1H_CYCLES - 1) : CW'(T0H_CYCLES - 1);
      strand_out <= 1'b1;
    end else begin
      case (phase)
        PH_HIGH: begin
          if (cnt == '0) begin
            phase      <= PH_LOW;
            strand_out <= 1'b0;
            cnt        <= bit_q ? CW'(T1L_CYCLES - 1) : CW'(T0L_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH_LOW: begin
          if (cnt == '0) phase <= PH_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/led_strand_driver.sv
// WS2812 strand driver: fetches GRB per LED, serialises 24 bits MSB first, latches between frames.
// First rise 2 cycles after latch end; one-LED prefetch hides fetch latency, empty buffer stalls the line low.
module led_strand_driver
  import led_strand_driver_pkg::*;
#(
  parameter int CLOCK_SPEED  = 100_000_000,
  parameter int NUM_LEDS     = 20,
  parameter int COLOR_WIDTH  = CHAN_W,
  parameter int T0H_CYCLES   = 35,
  parameter int T0L_CYCLES   = 80,
  parameter int T1H_CYCLES   = 70,
  parameter int T1L_CYCLES   = 60,
  parameter int RESET_CYCLES = 28_000
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  led_strand_driver_if.master bus,
  output logic                strand_out,
  output logic                frame_done,
  output logic                underrun_out
);

  localparam int LED_COUNTER_WIDTH = $clog2(NUM_LEDS);
  localparam int BITS = 3 * COLOR_WIDTH;
  localparam int BCW  = $clog2(BITS);
  localparam int TCW  = $clog2(max_of(max_of(max_of(T0H_CYCLES, T0L_CYCLES),
                                             max_of(T1H_CYCLES, T1L_CYCLES)),
                                      RESET_CYCLES) + 1);
  localparam logic [LED_COUNTER_WIDTH-1:0] LAST_IDX  = LED_COUNTER_WIDTH'(NUM_LEDS - 1);
  localparam logic [BCW-1:0]               LAST_BIT  = BCW'(BITS - 1);
  localparam logic [TCW-1:0]               LATCH_END = TCW'(RESET_CYCLES - 1);

  if (NUM_LEDS < 2 || CLOCK_SPEED <= 0) begin : g_bad_cfg
    $error("led_strand_driver: NUM_LEDS must be >= 2 and CLOCK_SPEED positive");
  end

  drv_state_t                   state;
  logic [TCW-1:0]               lcnt;
  logic [LED_COUNTER_WIDTH-1:0] idx;
  logic                         req_vld, req_age;
  logic [BITS-1:0]              shifter, buf_dat, color_in;
  logic                         buf_vld, buf_last, cur_last;
  logic [BCW-1:0]               bit_cnt;
  logic                         enc_start, enc_bit, enc_done;
  logic                         sample, boundary, direct_load, transfer, fill, new_last;

  assign bus.next_led_request = idx;
  assign bus.request_valid    = req_vld;
  assign color_in = {bus.green_in, bus.red_in, bus.blue_in};

  // The pattern registers colour from the index, so the index must have been stable a full cycle.
  assign sample      = req_vld & bus.color_ready & req_age;
  assign boundary    = (state == ST_SEND) & enc_done & (bit_cnt == LAST_BIT);
  assign transfer    = boundary & ~cur_last & buf_vld;
  assign direct_load = sample & ((state == ST_FETCH) | (state == ST_STALL) |
                                 (boundary & ~cur_last & ~buf_vld));
  assign fill        = sample & (state == ST_SEND) & ~buf_vld & ~boundary;
  assign new_last    = direct_load ? (idx == LAST_IDX) : buf_last;

  assign enc_start = direct_load | transfer |
                     ((state == ST_SEND) & enc_done & (bit_cnt != LAST_BIT));
  assign enc_bit   = direct_load ? color_in[BITS-1] :
                     transfer    ? buf_dat[BITS-1]  : shifter[BITS-2];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ST_LATCH;
      lcnt         <= '0;
      idx          <= '0;
      req_vld      <= 1'b0;
      req_age      <= 1'b0;
      shifter      <= '0;
      buf_dat      <= '0;
      buf_vld      <= 1'b0;
      buf_last     <= 1'b0;
      cur_last     <= 1'b0;
      bit_cnt      <= '0;
      frame_done   <= 1'b0;
      underrun_out <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      req_age    <= req_vld;
      case (state)
        ST_LATCH: begin
          if (lcnt == LATCH_END) begin
            lcnt    <= '0;
            idx     <= '0;
            req_vld <= 1'b1;
            state   <= ST_FETCH;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        ST_FETCH, ST_STALL: if (direct_load) state <= ST_SEND;
        ST_SEND: begin
          if (boundary) begin
            if (cur_last) begin
              frame_done <= 1'b1;
              state      <= ST_LATCH;
            end else if (!buf_vld && !sample) begin
              underrun_out <= 1'b1;
              state        <= ST_STALL;
            end
          end else if (enc_done) begin
            shifter <= shifter << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= ST_LATCH;
      endcase

      // Shifter reload: straight from the pattern or from the prefetch buffer.
      if (direct_load || transfer) begin
        shifter  <= direct_load ? color_in : buf_dat;
        bit_cnt  <= '0;
        cur_last <= new_last;
        if (transfer) buf_vld <= 1'b0;
        if (new_last) begin
          req_vld <= 1'b0;
        end else begin
          idx     <= idx + 1'b1;
          req_vld <= 1'b1;
          req_age <= 1'b0;
        end
      end

      if (fill) begin
        buf_dat  <= color_in;
        buf_vld  <= 1'b1;
        buf_last <= (idx == LAST_IDX);
        req_vld  <= 1'b0;
      end
    end
  end

  led_strand_driver_bit_encoder #(
    .T0H_CYCLES(T0H_CYCLES),
    .T0L_CYCLES(T0L_CYCLES),
    .T1H_CYCLES(T1H_CYCLES),
    .T1L_CYCLES(T1L_CYCLES)
  ) u_enc (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .start     (enc_start),
    .bit_in    (enc_bit),
    .done      (enc_done),
    .strand_out(strand_out)
  );

endmodule

// File: tb/tb_led_strand_driver.sv
// Directed bench: decodes the strand waveform and compares against hand-computed GRB words and timings.
module tb_led_strand_driver;
  import led_strand_driver_pkg::*;

  localparam int N   = 3;
  localparam int RST = 10;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  logic ready_en = 1'b1;
  logic strand_out, frame_done, underrun_out;

  always #5 clk_in = ~clk_in;

  led_strand_driver_if #(.COLOR_WIDTH(8), .LED_COUNTER_WIDTH(2)) bus ();

  led_strand_driver #(
    .CLOCK_SPEED(100_000_000), .NUM_LEDS(N), .COLOR_WIDTH(8),
    .T0H_CYCLES(2), .T0L_CYCLES(4), .T1H_CYCLES(4), .T1L_CYCLES(2),
    .RESET_CYCLES(RST)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .bus         (bus),
    .strand_out  (strand_out),
    .frame_done  (frame_done),
    .underrun_out(underrun_out)
  );

  // Pattern model: colour registered from the request index, one cycle of latency.
  led_color_t model_col [N];
  assign bus.color_ready = ready_en;
  always_ff @(posedge clk_in) begin
    bus.green_in <= model_col[int'(bus.next_led_request) % N].g;
    bus.red_in   <= model_col[int'(bus.next_led_request) % N].r;
    bus.blue_in  <= model_col[int'(bus.next_led_request) % N].b;
  end

  // Waveform monitor
  int   cyc, first_rise, hi_len, lo_len, fd_cnt;
  logic prev_s;
  logic [1:0] prev_req;
  int   hi_q[$], lo_q[$], req_log[$];
  logic bits_q[$];

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      cyc <= 0; first_rise <= -1; prev_s <= 1'b0; hi_len <= 0; lo_len <= 0;
      fd_cnt <= 0; prev_req <= 2'd0;
      bits_q.delete(); hi_q.delete(); lo_q.delete(); req_log.delete();
    end else begin
      cyc <= cyc + 1;
      if (strand_out) begin
        if (!prev_s) begin
          lo_q.push_back(lo_len);
          hi_len <= 1;
          if (first_rise < 0) first_rise <= cyc + 1;
        end else hi_len <= hi_len + 1;
      end else begin
        if (prev_s) begin
          hi_q.push_back(hi_len);
          bits_q.push_back(hi_len == 4);
          lo_len <= 1;
        end else lo_len <= lo_len + 1;
      end
      prev_s <= strand_out;
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (bus.next_led_request != prev_req) req_log.push_back(int'(bus.next_led_request));
      prev_req <= bus.next_led_request;
    end
  end

  typedef struct packed {
    led_color_t [N-1:0]       col;
    logic [N-1:0][23:0]       exp;
  } vec_t;

  vec_t vecs [4];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic led_color_t mkc(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    led_color_t c;
    c.g = g; c.r = r; c.b = b;
    return c;
  endfunction

  function automatic logic getbit(input int i);
    return (i < bits_q.size()) ? bits_q[i] : 1'b0;
  endfunction

  function automatic logic [23:0] word_at(input int base);
    logic [23:0] w = '0;
    for (int k = 0; k < 24; k++) w = {w[22:0], getbit(base + k)};
    return w;
  endfunction

  function automatic int hi_errors();
    int e = 0;
    for (int i = 0; i < hi_q.size(); i++)
      if (hi_q[i] != (bits_q[i] ? 4 : 2)) e++;
    return e;
  endfunction

  task automatic release_reset();
    @(negedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    ready_en = 1'b1;
    repeat (3) @(negedge clk_in);
    #1;
    check("reset_outputs",
          {bus.next_led_request, bus.request_valid, strand_out, frame_done, underrun_out}, 0);
    release_reset();
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    int k = 0;
    while (fd_cnt < n && k < budget) begin
      @(posedge clk_in); #1;
      k++;
    end
    check(name, fd_cnt, n);
  endtask

  task automatic load_model(input int v);
    for (int i = 0; i < N; i++) model_col[i] = vecs[v].col[i];
  endtask

  initial begin
    int exp_req [5];
    int e;
    exp_req = '{1, 2, 0, 1, 2};

    vecs[0].col[0] = mkc(8'hA5, 8'h0F, 8'hF0); vecs[0].exp[0] = 24'hA50FF0;
    vecs[0].col[1] = mkc(8'hA5, 8'h0F, 8'hF0); vecs[0].exp[1] = 24'hA50FF0;
    vecs[0].col[2] = mkc(8'hA5, 8'h0F, 8'hF0); vecs[0].exp[2] = 24'hA50FF0;
    vecs[1].col[0] = mkc(8'h00, 8'h00, 8'h00); vecs[1].exp[0] = 24'h000000;
    vecs[1].col[1] = mkc(8'h00, 8'h00, 8'h00); vecs[1].exp[1] = 24'h000000;
    vecs[1].col[2] = mkc(8'h00, 8'h00, 8'h00); vecs[1].exp[2] = 24'h000000;
    vecs[2].col[0] = mkc(8'hFF, 8'hFF, 8'hFF); vecs[2].exp[0] = 24'hFFFFFF;
    vecs[2].col[1] = mkc(8'hFF, 8'hFF, 8'hFF); vecs[2].exp[1] = 24'hFFFFFF;
    vecs[2].col[2] = mkc(8'hFF, 8'hFF, 8'hFF); vecs[2].exp[2] = 24'hFFFFFF;
    vecs[3].col[0] = mkc(8'h12, 8'h34, 8'h56); vecs[3].exp[0] = 24'h123456;
    vecs[3].col[1] = mkc(8'hAB, 8'hCD, 8'hEF); vecs[3].exp[1] = 24'hABCDEF;
    vecs[3].col[2] = mkc(8'h80, 8'h01, 8'h7E); vecs[3].exp[2] = 24'h80017E;

    // Two full frames per vector: words, bit timing, seamless LEDs, latch gap, requests.
    for (int v = 0; v < 4; v++) begin
      load_model(v);
      do_reset();
      wait_frames($sformatf("v%0d_frames", v), 2, 3000);
      repeat (3) @(posedge clk_in);
      #1;
      check($sformatf("v%0d_first_rise", v), first_rise, RST + 2);
      check($sformatf("v%0d_bit_count", v), bits_q.size(), 2 * N * 24);
      for (int f = 0; f < 2; f++)
        for (int l = 0; l < N; l++)
          check($sformatf("v%0d_f%0d_led%0d", v, f, l), word_at(f * 72 + l * 24), vecs[v].exp[l]);
      check($sformatf("v%0d_high_times", v), hi_errors(), 0);
      e = 0;
      for (int i = 1; i < lo_q.size(); i++)
        if (i != 72 && lo_q[i] != (bits_q[i-1] ? 2 : 4)) e++;
      check($sformatf("v%0d_low_times", v), e, 0);
      check($sformatf("v%0d_latch_gap", v), (lo_q.size() > 72) ? lo_q[72] : -1,
            (getbit(71) ? 2 : 4) + RST + 2);
      check($sformatf("v%0d_frame_done_cycles", v), fd_cnt, 2);
      check($sformatf("v%0d_no_underrun", v), underrun_out, 0);
      e = (req_log.size() == 5) ? 0 : 1;
      for (int i = 0; i < 5 && i < req_log.size(); i++)
        if (req_log[i] != exp_req[i]) e++;
      check($sformatf("v%0d_request_seq", v), e, 0);
    end

    // Pattern stalls while LED 1 is requested: underrun, line low, then correct resume.
    load_model(3);
    do_reset();
    e = 0;
    while (bus.next_led_request != 2'd1 && e < 100) begin
      @(posedge clk_in); #1;
      e++;
    end
    check("stall_req_idx1", bus.next_led_request, 1);
    ready_en = 1'b0;
    check("stall_no_underrun_yet", underrun_out, 0);
    repeat (200) @(posedge clk_in);
    #1;
    check("stall_underrun_set", underrun_out, 1);
    check("stall_line_low", strand_out, 0);
    check("stall_bits_sent", bits_q.size(), 24);
    ready_en = 1'b1;
    wait_frames("stall_frame", 1, 2000);
    repeat (2) @(posedge clk_in);
    #1;
    for (int l = 0; l < N; l++)
      check($sformatf("stall_led%0d", l), word_at(l * 24), vecs[3].exp[l]);
    check("stall_high_times", hi_errors(), 0);
    check("stall_underrun_sticky", underrun_out, 1);

    // Asynchronous reset during a high phase.
    load_model(0);
    do_reset();
    e = 0;
    while (!strand_out && e < 100) begin
      @(posedge clk_in); #1;
      e++;
    end
    @(posedge clk_in); #1;
    check("arst_was_high", strand_out, 1);
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_line_drop", strand_out, 0);
    check("arst_underrun_clear", underrun_out, 0);
    repeat (2) @(negedge clk_in);
    release_reset();
    wait_frames("arst_frame", 1, 2000);
    #1;
    check("arst_rise_delay_ok", first_rise >= RST + 2, 1);
    for (int l = 0; l < N; l++)
      check($sformatf("arst_led%0d", l), word_at(l * 24), vecs[0].exp[l]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
